// File: rtl/riscv_dcache_amo_seq_if.sv
// riscv_dcache_amo_seq_if: AMO sequencer bus (start/opcode, memory port, AMO ALU port, completion).
// master: memory stage + memory + ALU side; slave: the sequencer.
interface riscv_dcache_amo_seq_if;
  logic        i_riscv_amoseq_start;
  logic [4:0]  i_riscv_amoseq_ctrl;
  logic        i_riscv_amoseq_xlen;
  logic [63:0] i_riscv_amoseq_addr;
  logic [63:0] i_riscv_amoseq_rs2data;
  logic        o_riscv_amoseq_mem_req;
  logic        o_riscv_amoseq_mem_we;
  logic [63:0] o_riscv_amoseq_mem_addr;
  logic [7:0]  o_riscv_amoseq_mem_be;
  logic [63:0] o_riscv_amoseq_mem_wdata;
  logic        i_riscv_amoseq_mem_ready;
  logic [63:0] i_riscv_amoseq_mem_rdata;
  logic        o_riscv_amoseq_amo_enable;
  logic        o_riscv_amoseq_amo_xlen;
  logic [4:0]  o_riscv_amoseq_amo_ctrl;
  logic [63:0] o_riscv_amoseq_amo_rs1data;
  logic [63:0] o_riscv_amoseq_amo_rs2data;
  logic [63:0] i_riscv_amoseq_amo_result;
  logic [63:0] o_riscv_amoseq_rddata;
  logic        o_riscv_amoseq_done;
  logic        o_riscv_amoseq_misaligned;
  logic        o_riscv_amoseq_stall;
  modport master (
    output i_riscv_amoseq_start, i_riscv_amoseq_ctrl, i_riscv_amoseq_xlen, i_riscv_amoseq_addr,
           i_riscv_amoseq_rs2data, i_riscv_amoseq_mem_ready, i_riscv_amoseq_mem_rdata,
           i_riscv_amoseq_amo_result,
    input  o_riscv_amoseq_mem_req, o_riscv_amoseq_mem_we, o_riscv_amoseq_mem_addr,
           o_riscv_amoseq_mem_be, o_riscv_amoseq_mem_wdata, o_riscv_amoseq_amo_enable,
           o_riscv_amoseq_amo_xlen, o_riscv_amoseq_amo_ctrl, o_riscv_amoseq_amo_rs1data,
           o_riscv_amoseq_amo_rs2data, o_riscv_amoseq_rddata, o_riscv_amoseq_done,
           o_riscv_amoseq_misaligned, o_riscv_amoseq_stall
  );
  modport slave (
    input  i_riscv_amoseq_start, i_riscv_amoseq_ctrl, i_riscv_amoseq_xlen, i_riscv_amoseq_addr,
           i_riscv_amoseq_rs2data, i_riscv_amoseq_mem_ready, i_riscv_amoseq_mem_rdata,
           i_riscv_amoseq_amo_result,
    output o_riscv_amoseq_mem_req, o_riscv_amoseq_mem_we, o_riscv_amoseq_mem_addr,
           o_riscv_amoseq_mem_be, o_riscv_amoseq_mem_wdata, o_riscv_amoseq_amo_enable,
           o_riscv_amoseq_amo_xlen, o_riscv_amoseq_amo_ctrl, o_riscv_amoseq_amo_rs1data,
           o_riscv_amoseq_amo_rs2data, o_riscv_amoseq_rddata, o_riscv_amoseq_done,
           o_riscv_amoseq_misaligned, o_riscv_amoseq_stall
  );
endinterface

// File: rtl/riscv_dcache_amo_seq.sv
// riscv_dcache_amo_seq: read-modify-write AMO sequencer; ports: clk, sync active-high rst, bus (slave).
module riscv_dcache_amo_seq (
  input logic                  i_riscv_amoseq_clk,
  input logic                  i_riscv_amoseq_rst,
  riscv_dcache_amo_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, READ, CALC, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [4:0]  ctrl_q;
  logic        xlen_q;
  logic [63:0] addr_q;
  logic [63:0] rs2_q;
  logic [63:0] rdata_q;
  logic [63:0] result_q;
  logic        mis_q;
  logic        rst;
  logic        aligned;
  logic        go;
  logic [31:0] word;
  logic [63:0] loaded;
  assign rst = i_riscv_amoseq_rst;
  assign aligned = bus.i_riscv_amoseq_xlen ? (bus.i_riscv_amoseq_addr[2:0] == 3'd0)
                                           : (bus.i_riscv_amoseq_addr[1:0] == 2'd0);
  assign go = state == IDLE && bus.i_riscv_amoseq_start;
  assign word = addr_q[2] ? rdata_q[63:32] : rdata_q[31:0];
  assign loaded = xlen_q ? rdata_q : {{32{word[31]}}, word};
  always_ff @(posedge i_riscv_amoseq_clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = go && aligned ? READ : IDLE;
      READ:    state_n = bus.i_riscv_amoseq_mem_ready ? CALC : READ;
      CALC:    state_n = WRITE;
      WRITE:   state_n = bus.i_riscv_amoseq_mem_ready ? DONE : WRITE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_riscv_amoseq_clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      xlen_q   <= 1'b0;
      addr_q   <= '0;
      rs2_q    <= '0;
      rdata_q  <= '0;
      result_q <= '0;
      mis_q    <= 1'b0;
    end else begin
      mis_q <= go && !aligned;
      if (go) begin
        ctrl_q <= bus.i_riscv_amoseq_ctrl;
        xlen_q <= bus.i_riscv_amoseq_xlen;
        addr_q <= bus.i_riscv_amoseq_addr;
        rs2_q  <= bus.i_riscv_amoseq_rs2data;
      end
      if (state == READ && bus.i_riscv_amoseq_mem_ready)
        rdata_q <= bus.i_riscv_amoseq_mem_rdata;
      if (state == CALC)
        result_q <= bus.i_riscv_amoseq_amo_result;
    end
  end
  // Every output is gated by rst so nothing leaks while the state register is still being cleared.
  always_comb begin
    bus.o_riscv_amoseq_mem_req    = !rst && (state == READ || state == WRITE);
    bus.o_riscv_amoseq_mem_we     = !rst && state == WRITE;
    bus.o_riscv_amoseq_mem_addr   = rst ? '0 : {addr_q[63:3], 3'b000};
    bus.o_riscv_amoseq_mem_be     = rst ? '0 : xlen_q ? 8'hFF : addr_q[2] ? 8'hF0 : 8'h0F;
    bus.o_riscv_amoseq_mem_wdata  = rst ? '0 : xlen_q ? result_q : {2{result_q[31:0]}};
    bus.o_riscv_amoseq_amo_enable = !rst && state == CALC;
    bus.o_riscv_amoseq_amo_xlen   = !rst && xlen_q;
    bus.o_riscv_amoseq_amo_ctrl   = rst ? '0 : ctrl_q;
    bus.o_riscv_amoseq_amo_rs1data = rst ? '0 : loaded;
    bus.o_riscv_amoseq_amo_rs2data = rst ? '0 : rs2_q;
    bus.o_riscv_amoseq_rddata     = !rst && state == DONE ? loaded : '0;
    bus.o_riscv_amoseq_done       = !rst && state == DONE;
    bus.o_riscv_amoseq_misaligned = !rst && mis_q;
    bus.o_riscv_amoseq_stall      = !rst && (state == READ || state == CALC || state == WRITE || (go && aligned));
  end
endmodule
